// File: rtl/apb_init_bridge_if.sv
// Request/response and APB bus bundle for apb_init_bridge.
// master = the bridge itself, slave = the requester plus the APB responder side.
interface apb_init_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_write;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [2:0]            req_prot;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_W-1:0]     out_paddr;
  logic                  out_psel;
  logic                  out_penable;
  logic [2:0]            out_pprot;
  logic                  out_pwrite;
  logic [DATA_W-1:0]     out_pwdata;
  logic [DATA_W/8-1:0]   out_pstrb;
  logic                  out_pready;
  logic [DATA_W-1:0]     out_prdata;
  logic                  out_pslverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    input  rsp_ready, out_pready, out_prdata, out_pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot,
    output rsp_ready, out_pready, out_prdata, out_pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
  );
endinterface

// File: rtl/apb_init_bridge.sv
// Single-outstanding APB4 initiator: valid/ready request in, APB SETUP/ACCESS out,
// with a pready timeout so a hung responder cannot stall the requester.
//   state  | meaning
//   IDLE   | req_ready=1, waiting for a request
//   SETUP  | psel=1, penable=0 for one cycle
//   ACCESS | psel=1, penable=1, waiting for pready or timeout
//   RESP   | rsp_valid=1 until rsp_ready
module apb_init_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  apb_init_bridge_if.master   io_bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_strb;
  logic [2:0]          r_prot;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_tmo;
  logic                w_expired;

  assign w_expired = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_prot  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_addr  <= io_bus.req_addr;
            r_write <= io_bus.req_write;
            r_wdata <= io_bus.req_wdata;
            r_strb  <= io_bus.req_write ? io_bus.req_wstrb : '0;
            r_prot  <= io_bus.req_prot;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt   <= '0;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // pready wins over an expiring counter in the same cycle
          if (io_bus.out_pready) begin
            r_rdata <= r_write ? '0 : io_bus.out_prdata;
            r_err   <= io_bus.out_pslverr;
            r_tmo   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_expired) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_tmo   <= 1'b1;
            r_state <= S_RESP;
          end else if (TIMEOUT != 0) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (io_bus.rsp_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register so reset drops them without a clock.
  assign io_bus.req_ready   = (r_state == S_IDLE);
  assign io_bus.out_psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign io_bus.out_penable = (r_state == S_ACCESS);
  assign io_bus.rsp_valid   = (r_state == S_RESP);

  assign io_bus.rsp_rdata   = r_rdata;
  assign io_bus.rsp_err     = r_err;
  assign io_bus.rsp_timeout = r_tmo;
  assign io_bus.out_paddr   = r_addr;
  assign io_bus.out_pwrite  = r_write;
  assign io_bus.out_pwdata  = r_wdata;
  assign io_bus.out_pstrb   = r_strb;
  assign io_bus.out_pprot   = r_prot;
endmodule

// File: tb/tb_apb_init_bridge.sv
// Directed and randomized transfers through apb_init_bridge (TIMEOUT=4) with the
// expected response derived from wait count, direction and responder data.
module tb_apb_init_bridge;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  apb_init_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_init_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_req();
    bus.req_addr  = $urandom;
    bus.req_write = 1'($urandom);
    bus.req_wdata = $urandom;
    bus.req_wstrb = 4'($urandom);
    bus.req_prot  = 3'($urandom);
  endtask

  // One full transfer; waits = pready-low ACCESS cycles, hold = cycles rsp_ready stays low.
  task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [2:0] prot, input int waits,
                     input logic [31:0] prd, input logic serr, input int hold);
    logic        tmo;
    int          acc;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [3:0]  e_strb;
    tmo     = (waits >= T);
    acc     = tmo ? T : waits + 1;
    e_rdata = (tmo || wr) ? 32'd0 : prd;
    e_err   = tmo || serr;
    e_strb  = wr ? ws : 4'd0;

    check("idle_req_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    bus.req_prot  = prot;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble_req();
    check("setup_psel", 64'(bus.out_psel), 64'd1);
    check("setup_penable", 64'(bus.out_penable), 64'd0);
    check("setup_paddr", 64'(bus.out_paddr), 64'(addr));

    for (int c = 0; c < acc; c++) begin
      @(posedge clk); #1;
      check("access_psel", 64'(bus.out_psel), 64'd1);
      check("access_penable", 64'(bus.out_penable), 64'd1);
      check("access_paddr", 64'(bus.out_paddr), 64'(addr));
      check("access_pwrite", 64'(bus.out_pwrite), 64'(wr));
      check("access_pwdata", 64'(bus.out_pwdata), 64'(wd));
      check("access_pstrb", 64'(bus.out_pstrb), 64'(e_strb));
      check("access_pprot", 64'(bus.out_pprot), 64'(prot));
      check("access_req_ready", 64'(bus.req_ready), 64'd0);
      bus.out_pready  = (!tmo && c == waits);
      bus.out_prdata  = bus.out_pready ? prd : $urandom;
      bus.out_pslverr = bus.out_pready ? serr : 1'($urandom);
    end

    @(posedge clk); #1;
    bus.out_pready  = 1'b0;
    bus.out_prdata  = $urandom;
    bus.out_pslverr = 1'($urandom);
    check("resp_valid", 64'(bus.rsp_valid), 64'd1);
    check("resp_psel", 64'(bus.out_psel), 64'd0);
    check("resp_penable", 64'(bus.out_penable), 64'd0);
    check("resp_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
    check("resp_err", 64'(bus.rsp_err), 64'(e_err));
    check("resp_timeout", 64'(bus.rsp_timeout), 64'(tmo));

    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.out_pready = 1'($urandom);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
      check("hold_err", 64'(bus.rsp_err), 64'(e_err));
      check("hold_timeout", 64'(bus.rsp_timeout), 64'(tmo));
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
      check("hold_psel", 64'(bus.out_psel), 64'd0);
    end
    bus.out_pready = 1'b0;

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("done_req_ready", 64'(bus.req_ready), 64'd1);
    check("done_psel", 64'(bus.out_psel), 64'd0);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.rsp_ready   = 1'b0;
    bus.out_pready  = 1'b0;
    bus.out_prdata  = '0;
    bus.out_pslverr = 1'b0;
    scramble_req();

    #12;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_psel", 64'(bus.out_psel), 64'd0);
    check("rst_penable", 64'(bus.out_penable), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_paddr", 64'(bus.out_paddr), 64'd0);
    check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    check("rst_err", 64'(bus.rsp_err), 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // read zero-wait, write with 3 waits (pready on the last counter value), read with slverr
    txn(32'hA000_0010, 1'b0, 32'h0, 4'hF, 3'd0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    txn(32'h0000_0040, 1'b1, 32'h1234_5678, 4'b0110, 3'd2, 3, 32'hFFFF_FFFF, 1'b0, 0);
    txn(32'h0000_0080, 1'b0, 32'h5555_AAAA, 4'b1111, 3'd5, 1, 32'h0BAD_F00D, 1'b1, 0);
    txn(32'h0000_00C0, 1'b0, 32'h0, 4'h0, 3'd1, 100, 32'hCAFE_0000, 1'b0, 0);
    txn(32'h0000_0100, 1'b1, 32'h0F0F_0F0F, 4'b1001, 3'd7, 2, 32'h0, 1'b0, 10);

    // reset mid-ACCESS
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0200;
    bus.req_write = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_penable", 64'(bus.out_penable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_psel", 64'(bus.out_psel), 64'd0);
    check("async_penable", 64'(bus.out_penable), 64'd0);
    check("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("async_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_pready = 1'b1;
    @(posedge clk); #1;
    bus.out_pready = 1'b0;
    check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("post_rst_psel", 64'(bus.out_psel), 64'd0);
    txn(32'h0000_0300, 1'b0, 32'h0, 4'h0, 3'd0, 0, 32'h1357_9BDF, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] r;
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      r = $urandom;
      txn(a, 1'($urandom), d, 4'($urandom), 3'($urandom), int'($urandom_range(0, 5)),
          r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
